// File: rtl/ddr_req_dispatch.sv
// DDR4 request dispatcher: buffers host requests and issues them one at a time to the controller.
// Optional WAIT_ACK watchdog is enabled with the WAIT_TIMEOUT_EN macro.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing presented; arbitrates MR0 update vs. queued head
// WAIT_ACK | head entry presented on act_*, waiting for next_cmd
// MRS      | single-cycle MR0 burst-length update strobe
module ddr_req_dispatch #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_rw,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       act_cmd,
    output logic [ADDR_W-1:0]          act_addr,
    output logic [DATA_W-1:0]          act_data,
    output logic [1:0]                 dev_rw,
    input  logic                       dev_busy,
    input  logic                       next_cmd,
    input  logic                       mrs_req,
    input  logic [1:0]                 mrs_bl,
    output logic                       mrs_update,
    output logic [1:0]                 bl_update,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        MRS      = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic                rw_mem   [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                mrs_pending_q;
    logic [1:0]          mrs_bl_q;

    logic                act_cmd_q, act_cmd_d;
    logic [1:0]          dev_rw_q, dev_rw_d;
    logic [ADDR_W-1:0]   act_addr_q, act_addr_d;
    logic [DATA_W-1:0]   act_data_q, act_data_d;
    logic                mrs_update_q, mrs_update_d;
    logic [1:0]          bl_update_q, bl_update_d;

    logic                push, pop, issue, mrs_take, tmo_fire, tmr_expire;

    assign req_ready = (count_q < CNT_W'(DEPTH));
    assign push      = req_valid & req_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            rw_mem[wr_ptr_q]   <= req_rw;
            addr_mem[wr_ptr_q] <= req_addr;
            data_mem[wr_ptr_q] <= req_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        act_cmd_d    = act_cmd_q;
        dev_rw_d     = dev_rw_q;
        act_addr_d   = act_addr_q;
        act_data_d   = act_data_q;
        mrs_update_d = 1'b0;
        bl_update_d  = bl_update_q;
        pop          = 1'b0;
        issue        = 1'b0;
        mrs_take     = 1'b0;
        tmo_fire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!dev_busy) begin
                    if (mrs_pending_q) begin
                        state_d      = MRS;
                        mrs_update_d = 1'b1;
                        bl_update_d  = mrs_bl_q;
                        mrs_take     = 1'b1;
                    end else if (count_q != '0) begin
                        state_d    = WAIT_ACK;
                        issue      = 1'b1;
                        act_cmd_d  = 1'b1;
                        act_addr_d = addr_mem[rd_ptr_q];
                        act_data_d = data_mem[rd_ptr_q];
                        dev_rw_d   = rw_mem[rd_ptr_q] ? 2'b10 : 2'b01;
                    end
                end
            end
            WAIT_ACK: begin
                if (next_cmd) begin
                    pop       = 1'b1;
                    state_d   = IDLE;
                    act_cmd_d = 1'b0;
                    dev_rw_d  = 2'b00;
                end else if (tmr_expire) begin
                    // Head stays queued so the same entry is presented again.
                    tmo_fire  = 1'b1;
                    state_d   = IDLE;
                    act_cmd_d = 1'b0;
                    dev_rw_d  = 2'b00;
                end
            end
            MRS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mrs_pending_q <= 1'b0;
            mrs_bl_q      <= 2'b00;
            act_cmd_q     <= 1'b0;
            dev_rw_q      <= 2'b00;
            act_addr_q    <= '0;
            act_data_q    <= '0;
            mrs_update_q  <= 1'b0;
            bl_update_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            act_cmd_q    <= act_cmd_d;
            dev_rw_q     <= dev_rw_d;
            act_addr_q   <= act_addr_d;
            act_data_q   <= act_data_d;
            mrs_update_q <= mrs_update_d;
            bl_update_q  <= bl_update_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            // A request landing on the service edge survives with its new code.
            if (mrs_req) begin
                mrs_pending_q <= 1'b1;
                mrs_bl_q      <= mrs_bl;
            end else if (mrs_take) begin
                mrs_pending_q <= 1'b0;
            end
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] tmr_q;
    logic             tmo_q;

    assign tmr_expire = (state_q == WAIT_ACK) && (tmr_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (issue) begin
                tmr_q <= TMR_W'(TIMEOUT - 1);
            end else if ((state_q == WAIT_ACK) && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TMR_W'(1);
            end
            if (tmo_fire) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_q;
`else
    logic unused_tmo;

    assign tmr_expire  = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_tmo  = ^{issue, 32'(TIMEOUT), tmo_fire};
`endif

    assign act_cmd    = act_cmd_q;
    assign dev_rw     = dev_rw_q;
    assign act_addr   = act_addr_q;
    assign act_data   = act_data_q;
    assign mrs_update = mrs_update_q;
    assign bl_update  = bl_update_q;
    assign q_count    = count_q;

endmodule

// File: tb/tb_ddr_req_dispatch.sv
// Directed self-checking bench for ddr_req_dispatch (default parameters).
module tb_ddr_req_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic        act_cmd;
    logic [31:0] act_addr;
    logic [63:0] act_data;
    logic [1:0]  dev_rw;
    logic        dev_busy;
    logic        next_cmd;
    logic        mrs_req;
    logic [1:0]  mrs_bl;
    logic        mrs_update;
    logic [1:0]  bl_update;
    logic [3:0]  q_count;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    ddr_req_dispatch dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .act_cmd     (act_cmd),
        .act_addr    (act_addr),
        .act_data    (act_data),
        .dev_rw      (dev_rw),
        .dev_busy    (dev_busy),
        .next_cmd    (next_cmd),
        .mrs_req     (mrs_req),
        .mrs_bl      (mrs_bl),
        .mrs_update  (mrs_update),
        .bl_update   (bl_update),
        .q_count     (q_count),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_act(input string tag);
        int n = 0;
        while (act_cmd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, act_cmd}, 64'd1);
    endtask

    task automatic push(input logic rw, input logic [31:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        next_cmd = 1'b1;
        tick();
        next_cmd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
        dev_busy = 1'b0; next_cmd = 1'b0; mrs_req = 1'b0; mrs_bl = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_act_cmd", {63'd0, act_cmd}, 64'd0);
        chk("rst_dev_rw", {62'd0, dev_rw}, 64'd0);
        chk("rst_act_addr", {32'd0, act_addr}, 64'd0);
        chk("rst_act_data", act_data, 64'd0);
        chk("rst_q_count", {60'd0, q_count}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mrs_update", {63'd0, mrs_update}, 64'd0);
        chk("rst_bl_update", {62'd0, bl_update}, 64'd0);
        chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);

        // single write: issue one cycle after the push edge
        push(1'b1, 32'h0000_1040, 64'hDEAD_BEEF);
        chk("wr_q_after_push", {60'd0, q_count}, 64'd1);
        chk("wr_act_not_yet", {63'd0, act_cmd}, 64'd0);
        tick();
        chk("wr_act_cmd", {63'd0, act_cmd}, 64'd1);
        chk("wr_dev_rw", {62'd0, dev_rw}, 64'd2);
        chk("wr_act_addr", {32'd0, act_addr}, 64'h1040);
        chk("wr_act_data", act_data, 64'hDEAD_BEEF);
        tick();
        chk("wr_act_held", {63'd0, act_cmd}, 64'd1);
        ack();
        chk("wr_act_drop", {63'd0, act_cmd}, 64'd0);
        chk("wr_dev_rw_idle", {62'd0, dev_rw}, 64'd0);
        chk("wr_q_empty", {60'd0, q_count}, 64'd0);
        tick();
        chk("wr_no_reissue", {63'd0, act_cmd}, 64'd0);

        // fill with 8 reads, 9th dropped, drain in order
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 32'h100 + 32'(i * 16), 64'(i));
        end
        chk("full_q_count", {60'd0, q_count}, 64'd8);
        chk("full_req_ready", {63'd0, req_ready}, 64'd0);
        push(1'b0, 32'hDEAD, 64'hFF);
        chk("full_drop", {60'd0, q_count}, 64'd8);
        for (int i = 0; i < 8; i++) begin
            wait_act("full_wait_act");
            chk("full_order_addr", {32'd0, act_addr}, 64'h100 + 64'(i * 16));
            chk("full_order_rw", {62'd0, dev_rw}, 64'd1);
            ack();
            chk("full_pop_count", {60'd0, q_count}, 64'(7 - i));
        end
        tick();
        tick();
        chk("full_no_ninth", {63'd0, act_cmd}, 64'd0);
        chk("full_empty", {60'd0, q_count}, 64'd0);

        // dev_busy holds off issue; push+pop on one edge keeps count
        dev_busy = 1'b1;
        push(1'b1, 32'h200, 64'hA0);
        push(1'b1, 32'h210, 64'hA1);
        push(1'b1, 32'h220, 64'hA2);
        tick();
        tick();
        chk("busy_no_act", {63'd0, act_cmd}, 64'd0);
        chk("busy_q_count", {60'd0, q_count}, 64'd3);
        dev_busy = 1'b0;
        tick();
        chk("busy_rel_act", {63'd0, act_cmd}, 64'd1);
        chk("busy_rel_addr", {32'd0, act_addr}, 64'h200);
        chk("busy_rel_data", act_data, 64'hA0);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h230; req_data = 64'hA3;
        next_cmd  = 1'b1;
        tick();
        req_valid = 1'b0;
        next_cmd  = 1'b0;
        chk("pushpop_count", {60'd0, q_count}, 64'd3);
        wait_act("busy_wait1");
        chk("busy_addr1", {32'd0, act_addr}, 64'h210);
        chk("busy_rw1", {62'd0, dev_rw}, 64'd2);
        ack();
        wait_act("busy_wait2");
        chk("busy_addr2", {32'd0, act_addr}, 64'h220);
        ack();
        wait_act("busy_wait3");
        chk("busy_addr3", {32'd0, act_addr}, 64'h230);
        chk("busy_rw3", {62'd0, dev_rw}, 64'd1);
        ack();
        chk("busy_empty", {60'd0, q_count}, 64'd0);

        // MR0 update takes priority over queued traffic; last code wins
        dev_busy = 1'b1;
        push(1'b0, 32'h300, 64'h0);
        push(1'b1, 32'h310, 64'h1);
        mrs_req = 1'b1; mrs_bl = 2'b01;
        tick();
        mrs_bl = 2'b10;
        tick();
        mrs_req = 1'b0; mrs_bl = 2'b00;
        tick();
        chk("mrs_not_yet", {63'd0, mrs_update}, 64'd0);
        dev_busy = 1'b0;
        tick();
        chk("mrs_strobe", {63'd0, mrs_update}, 64'd1);
        chk("mrs_code", {62'd0, bl_update}, 64'd2);
        chk("mrs_no_act", {63'd0, act_cmd}, 64'd0);
        tick();
        chk("mrs_strobe_end", {63'd0, mrs_update}, 64'd0);
        chk("mrs_code_hold", {62'd0, bl_update}, 64'd2);
        chk("mrs_still_no_act", {63'd0, act_cmd}, 64'd0);
        tick();
        chk("mrs_then_act", {63'd0, act_cmd}, 64'd1);
        chk("mrs_then_addr", {32'd0, act_addr}, 64'h300);
        chk("mrs_once", {63'd0, mrs_update}, 64'd0);
        ack();
        wait_act("mrs_wait2");
        chk("mrs_addr2", {32'd0, act_addr}, 64'h310);
        ack();

        // reset in WAIT_ACK with 4 queued
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 32'h500 + 32'(i), 64'(i));
        end
        chk("rstmid_act", {63'd0, act_cmd}, 64'd1);
        chk("rstmid_q", {60'd0, q_count}, 64'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_act_clr", {63'd0, act_cmd}, 64'd0);
        chk("rstmid_rw_clr", {62'd0, dev_rw}, 64'd0);
        chk("rstmid_q_clr", {60'd0, q_count}, 64'd0);
        chk("rstmid_ready", {63'd0, req_ready}, 64'd1);
        tick();
        tick();
        chk("rstmid_discard", {63'd0, act_cmd}, 64'd0);

        // watchdog behaviour with next_cmd withheld
        push(1'b1, 32'h400, 64'h77);
        tick();
        chk("tmo_issue", {63'd0, act_cmd}, 64'd1);
`ifdef WAIT_TIMEOUT_EN
        repeat (63) tick();
        chk("tmo_still_waiting", {63'd0, act_cmd}, 64'd1);
        chk("tmo_not_set", {63'd0, timeout_err}, 64'd0);
        tick();
        chk("tmo_err_set", {63'd0, timeout_err}, 64'd1);
        chk("tmo_act_drop", {63'd0, act_cmd}, 64'd0);
        chk("tmo_rw_drop", {62'd0, dev_rw}, 64'd0);
        chk("tmo_no_pop", {60'd0, q_count}, 64'd1);
        tick();
        chk("tmo_reissue", {63'd0, act_cmd}, 64'd1);
        chk("tmo_reissue_addr", {32'd0, act_addr}, 64'h400);
        ack();
        chk("tmo_sticky", {63'd0, timeout_err}, 64'd1);
`else
        repeat (100) tick();
        chk("notmo_still_waiting", {63'd0, act_cmd}, 64'd1);
        chk("notmo_err_zero", {63'd0, timeout_err}, 64'd0);
        ack();
`endif
        chk("tmo_final_empty", {60'd0, q_count}, 64'd0);
        chk("tmo_final_idle", {63'd0, act_cmd}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
